// File: rtl/regfile_hilo.sv
// Architectural GPR file (r0 hardwired to zero) plus the HI/LO pair.
// Reads are combinational with a same-cycle write-first bypass. wr_cnt counts retired GPR writes.
module regfile_hilo #(
  parameter int NREG   = 32,
  parameter int WORD_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rfwe,
  input  logic [$clog2(NREG)-1:0] rfwa,
  input  logic [WORD_W-1:0]       rfwd,
  input  logic                    hilowe,
  input  logic [WORD_W-1:0]       hi_i,
  input  logic [WORD_W-1:0]       lo_i,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  output logic [WORD_W-1:0]       rs_data,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  output logic [WORD_W-1:0]       rt_data,
  output logic [WORD_W-1:0]       hi_o,
  output logic [WORD_W-1:0]       lo_o,
  output logic [31:0]             wr_cnt
);

  localparam int AW = $clog2(NREG);

  logic [WORD_W-1:0] regs_q [NREG];
  logic [WORD_W-1:0] hi_q, lo_q;
  logic [31:0]       wr_cnt_q, wr_cnt_d;
  logic              gpr_we;

  assign gpr_we = rfwe && (rfwa != '0);

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (gpr_we) wr_cnt_d = wr_cnt_q + 32'd1;
  end

  // NOTE: the storage array is reset in full because reads must never expose X,
  // even for registers that have not been written since power-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (gpr_we) regs_q[rfwa] <= rfwd;
      if (hilowe) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

  function automatic logic [WORD_W-1:0] gpr_read(input logic [AW-1:0] addr);
    if (addr == '0)                 return '0;
    else if (rfwe && rfwa == addr)  return rfwd;
    else                            return regs_q[addr];
  endfunction

  // Reset forces every read to zero and suppresses the bypass paths.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    hi_o    = '0;
    lo_o    = '0;
    if (!rst) begin
      rs_data = gpr_read(rs_addr);
      rt_data = gpr_read(rt_addr);
      hi_o    = hilowe ? hi_i : hi_q;
      lo_o    = hilowe ? lo_i : lo_q;
    end
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed self-checking bench for regfile_hilo: reset, r0, write/read, bypass,
// HI/LO, reset mid-stream and counter wrap.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        rfwe;
  logic [4:0]  rfwa;
  logic [31:0] rfwd;
  logic        hilowe;
  logic [31:0] hi_i, lo_i;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, hi_o, lo_o, wr_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_hilo dut (
    .clk     (clk),
    .rst     (rst),
    .rfwe    (rfwe),
    .rfwa    (rfwa),
    .rfwd    (rfwd),
    .hilowe  (hilowe),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .rs_addr (rs_addr),
    .rs_data (rs_data),
    .rt_addr (rt_addr),
    .rt_data (rt_data),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .wr_cnt  (wr_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rfwe = 1'b0; rfwa = '0; rfwd = '0;
    hilowe = 1'b0; hi_i = '0; lo_i = '0; rs_addr = '0; rt_addr = '0;

    // Reset held for two cycles, then scan all addresses on both ports.
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      check($sformatf("rst_rs[%0d]", a), rs_data, 32'h0);
      check($sformatf("rst_rt[%0d]", 31 - a), rt_data, 32'h0);
    end
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_cnt", wr_cnt, 32'h0);

    // r0 write is discarded and not counted.
    rfwe = 1'b1; rfwa = 5'd0; rfwd = 32'hDEADBEEF; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("r0_same_cycle", rs_data, 32'h0);
    tick();
    rfwe = 1'b0;
    #1;
    check("r0_next_cycle", rs_data, 32'h0);
    check("r0_cnt", wr_cnt, 32'h0);

    // Write then read on both ports.
    rfwe = 1'b1; rfwa = 5'd5; rfwd = 32'h12345678;
    tick();
    rfwe = 1'b0; rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    check("wr5_rs", rs_data, 32'h12345678);
    check("wr5_rt", rt_data, 32'h12345678);
    check("wr5_cnt", wr_cnt, 32'd1);

    // Preload r7 and r8, then bypass r7 while r8 reads from storage.
    rfwe = 1'b1; rfwa = 5'd7; rfwd = 32'hAAAAAAAA;
    tick();
    rfwa = 5'd8; rfwd = 32'h88888888;
    tick();
    rfwa = 5'd7; rfwd = 32'h55555555; rs_addr = 5'd7; rt_addr = 5'd8;
    #1;
    check("byp_rs7", rs_data, 32'h55555555);
    check("byp_rt8", rt_data, 32'h88888888);
    tick();
    rfwe = 1'b0;
    #1;
    check("byp_rs7_held", rs_data, 32'h55555555);
    check("byp_cnt", wr_cnt, 32'd4);

    // Both ports bypassing the same register.
    rfwe = 1'b1; rfwa = 5'd9; rfwd = 32'h0000_0009; rs_addr = 5'd9; rt_addr = 5'd9;
    #1;
    check("dual_byp_rs", rs_data, 32'h9);
    check("dual_byp_rt", rt_data, 32'h9);
    tick();
    rfwe = 1'b0;
    #1;
    check("dual_byp_cnt", wr_cnt, 32'd5);

    // HI/LO bypass and hold.
    hilowe = 1'b1; hi_i = 32'h00000001; lo_i = 32'hFFFFFFFE;
    #1;
    check("hilo_byp_hi", hi_o, 32'h00000001);
    check("hilo_byp_lo", lo_o, 32'hFFFFFFFE);
    tick();
    hilowe = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
    #1;
    check("hilo_hold_hi", hi_o, 32'h00000001);
    check("hilo_hold_lo", lo_o, 32'hFFFFFFFE);

    // Concurrent GPR and HI/LO writes.
    rfwe = 1'b1; rfwa = 5'd31; rfwd = 32'h42;
    hilowe = 1'b1; hi_i = 32'hCAFE0000; lo_i = 32'h0000BEEF;
    tick();
    rfwe = 1'b0; hilowe = 1'b0; hi_i = 32'h0; lo_i = 32'h0; rs_addr = 5'd31; rt_addr = 5'd5;
    #1;
    check("conc_r31", rs_data, 32'h42);
    check("conc_r5", rt_data, 32'h12345678);
    check("conc_hi", hi_o, 32'hCAFE0000);
    check("conc_lo", lo_o, 32'h0000BEEF);
    check("conc_cnt", wr_cnt, 32'd6);

    // Reset mid-stream: write and bypass suppressed, reads forced to zero.
    rst = 1'b1; rfwe = 1'b1; rfwa = 5'd3; rfwd = 32'h99; rs_addr = 5'd3;
    hilowe = 1'b1; hi_i = 32'h5; lo_i = 32'h6;
    #1;
    check("rst_mid_rs3", rs_data, 32'h0);
    check("rst_mid_rt5", rt_data, 32'h0);
    check("rst_mid_hi", hi_o, 32'h0);
    check("rst_mid_lo", lo_o, 32'h0);
    tick();
    rst = 1'b0; rfwe = 1'b0; hilowe = 1'b0; hi_i = '0; lo_i = '0;
    #1;
    check("post_rst_r3", rs_data, 32'h0);
    check("post_rst_r5", rt_data, 32'h0);
    check("post_rst_hi", hi_o, 32'h0);
    check("post_rst_cnt", wr_cnt, 32'h0);

    // Counter wrap from all-ones.
    force dut.wr_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    check("wrap_pre", wr_cnt, 32'hFFFFFFFF);
    rfwe = 1'b1; rfwa = 5'd1; rfwd = 32'h11; rs_addr = 5'd1;
    tick();
    rfwe = 1'b0;
    #1;
    check("wrap_cnt", wr_cnt, 32'h0);
    check("wrap_r1", rs_data, 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
